// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake bundle for the bit-serial adder controller.
// Port sub exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (
        output start_valid, a, b, cin, sub, done_ready,
        input  start_ready, done_valid, sum, cout, busy
    );
    modport slave (
        input  start_valid, a, b, cin, sub, done_ready,
        output start_ready, done_valid, sum, cout, busy
    );
`else
    modport master (
        output start_valid, a, b, cin, done_ready,
        input  start_ready, done_valid, sum, cout, busy
    );
    modport slave (
        input  start_valid, a, b, cin, done_ready,
        output start_ready, done_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full adder sequenced over WIDTH cycles.
// Optional subtraction (A-B) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             ha0_s, ha0_c, ha1_s, ha1_c;
    logic             fa_sum, fa_carry;
    logic [WIDTH-1:0] res_shift;
    logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as A + ~B + 1; cin is ignored in that mode.
    assign b_load = bus.sub ? ~bus.b : bus.b;
    assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_load = bus.b;
    assign c_load = bus.cin;
`endif

    // Full adder built from two half adders plus an OR on the carries.
    assign ha0_s    = op_a_q[0] ^ op_b_q[0];
    assign ha0_c    = op_a_q[0] & op_b_q[0];
    assign ha1_s    = ha0_s ^ carry_q;
    assign ha1_c    = ha0_s & carry_q;
    assign fa_sum   = ha1_s;
    assign fa_carry = ha0_c | ha1_c;

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = fa_sum;
        end else begin : g_res_wn
            assign res_shift = {fa_sum, res_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                // res_q is left alone so the previous sum stays visible.
                if (bus.start_valid) begin
                    op_a_d  = bus.a;
                    op_b_d  = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                res_d   = res_shift;
                carry_d = fa_carry;
                cnt_d   = cnt_q + CntW'(1);
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.done_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.start_ready = (state_q == StIdle);
    assign bus.done_valid  = (state_q == StDone);
    assign bus.busy        = (state_q != StIdle);
    assign bus.sum         = res_q;
    assign bus.cout        = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
// Subtraction cases run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_sel = 1'b0;
    assign bus.sub = sub_sel;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Present operands at a negedge; accepted on the following posedge.
    task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        bus.a           = av;
        bus.b           = bv;
        bus.cin         = cv;
        bus.start_valid = 1'b1;
        @(negedge clk);
        bus.start_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until done_valid is seen.
    task automatic wait_done(output int cycles, output bit busy_ok);
        cycles  = 0;
        busy_ok = 1'b1;
        while (!bus.done_valid && cycles < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cycles++;
        end
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic finish_done();
        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.start_ready !== 1'b1)
            begin errors++; $display("FAIL reset_start_ready got=%b exp=1", bus.start_ready); end
        checks++; if (bus.done_valid !== 1'b0)
            begin errors++; $display("FAIL reset_done_valid got=%b exp=0", bus.done_valid); end
        checks++; if (bus.busy !== 1'b0)
            begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.sum !== 8'h00)
            begin errors++; $display("FAIL reset_sum got=%h exp=00", bus.sum); end
        checks++; if (bus.cout !== 1'b0)
            begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_add();
        int cyc;
        bit bok;
        do_start(8'h3C, 8'h05, 1'b0);
        wait_done(cyc, bok);
        checks++; if (cyc !== 8)
            begin errors++; $display("FAIL basic_latency got=%0d exp=8", cyc); end
        checks++; if (bok !== 1'b1)
            begin errors++; $display("FAIL basic_busy got=%b exp=1", bok); end
        checks++; if (bus.sum !== 8'h41)
            begin errors++; $display("FAIL basic_sum got=%h exp=41", bus.sum); end
        checks++; if (bus.cout !== 1'b0)
            begin errors++; $display("FAIL basic_cout got=%b exp=0", bus.cout); end
        finish_done();
        checks++; if (bus.start_ready !== 1'b1)
            begin errors++; $display("FAIL basic_ready_after got=%b exp=1", bus.start_ready); end
        checks++; if (bus.sum !== 8'h41)
            begin errors++; $display("FAIL basic_sum_held_idle got=%h exp=41", bus.sum); end
    endtask

    task automatic test_carry_edges();
        int cyc;
        bit bok;
        do_start(8'hFF, 8'h01, 1'b0);
        wait_done(cyc, bok);
        checks++; if (bus.sum !== 8'h00)
            begin errors++; $display("FAIL wrap_sum got=%h exp=00", bus.sum); end
        checks++; if (bus.cout !== 1'b1)
            begin errors++; $display("FAIL wrap_cout got=%b exp=1", bus.cout); end
        finish_done();
        do_start(8'hFF, 8'hFF, 1'b1);
        wait_done(cyc, bok);
        checks++; if (bus.sum !== 8'hFF)
            begin errors++; $display("FAIL max_sum got=%h exp=ff", bus.sum); end
        checks++; if (bus.cout !== 1'b1)
            begin errors++; $display("FAIL max_cout got=%b exp=1", bus.cout); end
        finish_done();
    endtask

    task automatic test_backpressure();
        int cyc;
        bit bok;
        bit stable;
        logic [W-1:0] s0;
        logic c0;
        do_start(8'h5A, 8'hA5, 1'b1);
        wait_done(cyc, bok);
        s0 = bus.sum;
        c0 = bus.cout;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.sum !== s0 || bus.cout !== c0 || bus.done_valid !== 1'b1 ||
                bus.start_ready !== 1'b0) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1)
            begin errors++; $display("FAIL bp_stable got=%b exp=1", stable); end
        checks++; if (bus.sum !== 8'h00 || bus.cout !== 1'b1)
            begin errors++; $display("FAIL bp_result got=%b_%h exp=1_00", bus.cout, bus.sum); end
        finish_done();
        checks++; if (bus.start_ready !== 1'b1)
            begin errors++; $display("FAIL bp_ready_after got=%b exp=1", bus.start_ready); end
        checks++; if (bus.done_valid !== 1'b0)
            begin errors++; $display("FAIL bp_valid_after got=%b exp=0", bus.done_valid); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        bit bok;
        do_start(8'h21, 8'h13, 1'b0);
        bus.a           = 8'hFF;
        bus.b           = 8'hFF;
        bus.cin         = 1'b1;
        bus.start_valid = 1'b1;
        wait_done(cyc, bok);
        bus.start_valid = 1'b0;
        checks++; if (cyc !== 8)
            begin errors++; $display("FAIL ign_latency got=%0d exp=8", cyc); end
        checks++; if (bus.sum !== 8'h34)
            begin errors++; $display("FAIL ign_sum got=%h exp=34", bus.sum); end
        checks++; if (bus.cout !== 1'b0)
            begin errors++; $display("FAIL ign_cout got=%b exp=0", bus.cout); end
        finish_done();
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        bit bok;
        bit seen;
        do_start(8'hAA, 8'h55, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL mid_rst_ctrl got=%b%b exp=10", bus.start_ready, bus.busy); end
        checks++; if (bus.done_valid !== 1'b0)
            begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", bus.done_valid); end
        checks++; if (bus.sum !== 8'h00 || bus.cout !== 1'b0)
            begin errors++; $display("FAIL mid_rst_result got=%b_%h exp=0_00", bus.cout, bus.sum); end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0)
            begin errors++; $display("FAIL mid_rst_no_done got=%b exp=0", seen); end
        do_start(8'h12, 8'h34, 1'b0);
        wait_done(cyc, bok);
        checks++; if (bus.sum !== 8'h46 || bus.cout !== 1'b0)
            begin errors++; $display("FAIL post_rst_add got=%b_%h exp=0_46", bus.cout, bus.sum); end
        finish_done();
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_subtract();
        int cyc;
        bit bok;
        sub_sel = 1'b1;
        do_start(8'h10, 8'h01, 1'b0);
        wait_done(cyc, bok);
        checks++; if (bus.sum !== 8'h0F || bus.cout !== 1'b1)
            begin errors++; $display("FAIL sub_no_borrow got=%b_%h exp=1_0f", bus.cout, bus.sum); end
        finish_done();
        do_start(8'h00, 8'h01, 1'b0);
        wait_done(cyc, bok);
        checks++; if (bus.sum !== 8'hFF || bus.cout !== 1'b0)
            begin errors++; $display("FAIL sub_borrow got=%b_%h exp=0_ff", bus.cout, bus.sum); end
        finish_done();
        sub_sel = 1'b0;
    endtask
`endif

    initial begin
        bus.start_valid = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.cin         = 1'b0;
        bus.done_ready  = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_add();
        test_carry_edges();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_op();
`ifdef SERIAL_ADDER_SUB_EN
        test_subtract();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
